// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet controller.
// Holds the FSM state encoding, the default sync marker and the running
// checksum step used while a packet is being framed.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4,
    HOLD    = 3'd5
  } pkt_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // One step of the packet checksum (XOR over CMD, LEN and payload).
  function automatic logic [7:0] chk_next(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port.
// Ports: clk; we_i/waddr_i/wdata_i write; raddr_i -> rdata_o read.
// Contents are deliberately not reset.
module uart_pkt_buf
  import uart_pkt_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the UART byte stream into SYNC,CMD,LEN,PAYLOAD,CSUM packets,
// checks length/checksum and holds a good packet for the consumer.
// Ports: clk/rst; i_rx_data/i_rx_valid byte strobe (no backpressure);
// o_pkt_valid/i_pkt_ready handshake with o_pkt_cmd/o_pkt_len;
// i_rd_addr -> o_rd_data payload read; o_err_*/o_drop single-cycle pulses.
module uart_rx_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = 8680,
  localparam int        LW           = $clog2(MAX_LEN + 1),
  localparam int        AW           = $clog2(MAX_LEN),
  localparam int        CW           = $clog2(TIMEOUT_CLKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_pkt_valid,
  input  logic          i_pkt_ready,
  output logic [7:0]    o_pkt_cmd,
  output logic [LW-1:0] o_pkt_len,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_err_csum,
  output logic          o_err_len,
  output logic          o_err_timeout,
  output logic          o_drop
);

  pkt_state_t    state_q;
  logic [7:0]    cmd_q;
  logic [LW-1:0] len_q;
  logic [7:0]    chk_q;
  logic [AW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          err_csum_q;
  logic          err_len_q;
  logic          err_tmo_q;
  logic          drop_q;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          tmo_hit;
  logic          last_pl;

  assign buf_we  = (state_q == PAYLOAD) && i_rx_valid;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CLKS - 1));
  // Current payload byte is the final one when idx+1 reaches len.
  assign last_pl = ((LW'(idx_q) + LW'(1)) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      err_csum_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      err_csum_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      drop_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (i_rx_valid && (i_rx_data == SYNC_BYTE)) state_q <= CMD;
        end
        HOLD: begin
          // Every byte here is lost, including one in the handshake cycle.
          if (i_rx_valid) drop_q <= 1'b1;
          if (i_pkt_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          // In-packet states: a byte always beats an expiring timeout.
          if (i_rx_valid) begin
            cnt_q <= '0;
            case (state_q)
              CMD: begin
                cmd_q   <= i_rx_data;
                chk_q   <= i_rx_data;
                state_q <= LEN;
              end
              LEN: begin
                if (int'(i_rx_data) > MAX_LEN) begin
                  err_len_q <= 1'b1;
                  state_q   <= IDLE;
                end else begin
                  len_q   <= LW'(i_rx_data);
                  chk_q   <= chk_next(chk_q, i_rx_data);
                  state_q <= (i_rx_data == 8'h00) ? CSUM : PAYLOAD;
                end
              end
              PAYLOAD: begin
                chk_q <= chk_next(chk_q, i_rx_data);
                if (last_pl) begin
                  idx_q   <= '0;
                  state_q <= CSUM;
                end else begin
                  idx_q <= idx_q + AW'(1);
                end
              end
              CSUM: begin
                if (i_rx_data == chk_q) begin
                  valid_q <= 1'b1;
                  state_q <= HOLD;
                end else begin
                  err_csum_q <= 1'b1;
                  state_q    <= IDLE;
                end
              end
              default: state_q <= IDLE;
            endcase
          end else if (tmo_hit) begin
            err_tmo_q <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (i_rx_data),
    .raddr_i (i_rd_addr),
    .rdata_o (buf_rdata)
  );

  // Reads outside the held packet (or with nothing held) return zero.
  assign o_rd_data     = (valid_q && (LW'(i_rd_addr) < len_q)) ? buf_rdata : 8'h00;
  assign o_pkt_valid   = valid_q;
  assign o_pkt_cmd     = cmd_q;
  assign o_pkt_len     = len_q;
  assign o_err_csum    = err_csum_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_tmo_q;
  assign o_drop        = drop_q;

endmodule
